// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// Optional burst lock (up to MAX_BURST beats per grant) enabled by defining FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = $clog2(NREQ),
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       fifo_wr,
  output logic [DATA_WIDTH-1:0]      fifo_data,
  output logic [ID_WIDTH-1:0]        fifo_tag,
  input  logic                       fifo_full,
  output logic                       busy
);

  if (NREQ < 2 || NREQ > 16 || MAX_BURST < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: NREQ must be 2..16 and MAX_BURST >= 1");
  end

  localparam logic [ID_WIDTH-1:0] LastIdx = ID_WIDTH'(NREQ - 1);

  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ID_WIDTH-1:0]   tag_q, tag_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

  logic                  found_hi, found_lo;
  logic [ID_WIDTH-1:0]   hi_idx, lo_idx, win_idx;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  can_load, transfer;

  function automatic logic [ID_WIDTH-1:0] inc_ptr(input logic [ID_WIDTH-1:0] p);
    return (p == LastIdx) ? '0 : p + 1'b1;
  endfunction

  // Wrapping search from rr_ptr: the first valid at or above the pointer wins,
  // otherwise the lowest valid index overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        if (!found_hi && (ID_WIDTH'(i) >= rr_ptr_q)) begin
          found_hi = 1'b1;
          hi_idx   = ID_WIDTH'(i);
        end
        if (!found_lo) begin
          found_lo = 1'b1;
          lo_idx   = ID_WIDTH'(i);
        end
      end
    end
    win_idx = found_hi ? hi_idx : lo_idx;
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (ID_WIDTH'(i) == win_idx) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign can_load = !wr_q || !fifo_full;
  assign transfer = found_lo && en && can_load;

  always_comb begin
    req_ready = '0;
    if (transfer) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    wr_d   = wr_q;
    data_d = data_q;
    tag_d  = tag_q;
    if (transfer) begin
      wr_d   = 1'b1;
      data_d = win_data;
      tag_d  = win_idx;
    end else if (can_load) begin
      wr_d   = 1'b0;
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned BCW = $clog2(MAX_BURST) + 1;

  logic [BCW-1:0] burst_cnt_q, burst_cnt_d, cnt;

  // A nonzero count means the pointer is parked on the locked owner; losing
  // its valid (or hitting the cap) releases the lock and advances the pointer.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    cnt         = ((burst_cnt_q != '0) && (win_idx == rr_ptr_q)) ? burst_cnt_q : '0;
    if (transfer) begin
      if (cnt == BCW'(MAX_BURST - 1)) begin
        rr_ptr_d    = inc_ptr(win_idx);
        burst_cnt_d = '0;
      end else begin
        rr_ptr_d    = win_idx;
        burst_cnt_d = cnt + 1'b1;
      end
    end else if (en && (burst_cnt_q != '0) && !req_valid[rr_ptr_q]) begin
      rr_ptr_d    = inc_ptr(rr_ptr_q);
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_cnt_q <= '0;
    else     burst_cnt_q <= burst_cnt_d;
  end
`else
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (transfer) rr_ptr_d = inc_ptr(win_idx);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      data_q   <= '0;
      tag_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      wr_q     <= wr_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign fifo_wr   = wr_q;
  assign fifo_data = data_q;
  assign fifo_tag  = tag_q;
  assign busy      = wr_q || (|req_valid);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed stimulus pushes expected beats,
// a negedge monitor pops and compares every beat that leaves the output stage.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_data;
  logic [IW-1:0]     fifo_tag;
  logic              fifo_full;
  logic              busy;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] t;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .fifo_tag  (fifo_tag),
    .fifo_full (fifo_full),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push(input logic [DW-1:0] d, input int t);
    beat_t b;
    b.d = d;
    b.t = IW'(t);
    exp_q.push_back(b);
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    fifo_full = 1'b0;
    en        = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: a beat leaves the stage at each edge where fifo_wr && !fifo_full.
  always @(negedge clk) begin
    if (!rst && fifo_wr && !fifo_full) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {fifo_data, fifo_tag}, '0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", 64'(fifo_data), 64'(e.d));
        check("beat_tag", 64'(fifo_tag), 64'(e.t));
      end
    end
  end

  initial begin
    req_data  = '0;
    req_valid = '0;
    en        = 1'b1;
    fifo_full = 1'b0;
    rst       = 1'b1;
    #2;
    check("reset_wr", 64'(fifo_wr), 0);
    check("reset_data", 64'(fifo_data), 0);
    check("reset_tag", 64'(fifo_tag), 0);
    check("reset_ready", 64'(req_ready), 0);
    do_reset();

    // Idle
    for (int c = 0; c < 20; c++) begin
      check("idle", {fifo_wr, busy, req_ready}, 0);
      tick();
    end

    // Single requester 2
    req_valid = 4'b0100;
    set_data(2, 32'hA5A5_0002);
    #1;
    check("single_ready", 64'(req_ready), 64'h4);
    check("single_busy", 64'(busy), 1);
    push(32'hA5A5_0002, 2);
    tick();
    req_valid = '0;
    check("single_wr", 64'(fifo_wr), 1);
    tick();
    check("single_drain", 64'(fifo_wr), 0);

    // Fairness with all four valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_data(i, 32'hD000_0000 + 32'(i));
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
`ifdef FIFO_ARB_BURST_EN
      push(32'hD000_0000 + 32'((k / 4) % 4), (k / 4) % 4);
`else
      push(32'hD000_0000 + 32'(k % 4), k % 4);
`endif
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      check("rr_wr_cont", 64'(fifo_wr), 1);
    end
    req_valid = '0;
    tick();
    check("rr_drain", 64'(fifo_wr), 0);

    // Backpressure hold then no-bubble reload
    do_reset();
    fifo_full = 1'b1;
    req_valid = 4'b0010;
    set_data(1, 32'h0000_00B1);
    #1;
    check("full_empty_ready", 64'(req_ready), 64'h2);
    tick();
    set_data(1, 32'h0000_00B2);
    for (int c = 0; c < 5; c++) begin
      check("hold_ready", 64'(req_ready), 0);
      check("hold_wr", 64'(fifo_wr), 1);
      check("hold_data", 64'(fifo_data), 64'hB1);
      check("hold_tag", 64'(fifo_tag), 1);
      tick();
    end
    push(32'h0000_00B1, 1);
    push(32'h0000_00B2, 1);
    fifo_full = 1'b0;
    #1;
    check("release_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    check("nobubble_wr", 64'(fifo_wr), 1);
    check("nobubble_data", 64'(fifo_data), 64'hB2);
    tick();
    check("release_drain", 64'(fifo_wr), 0);

    // Enable low: no grants, pointer frozen, pending beat drains
    do_reset();
    for (int i = 0; i < NREQ; i++) set_data(i, 32'h0000_00C0 + 32'(i));
    req_valid = 4'b0001;
    push(32'h0000_00C0, 0);
    tick();
    req_valid = 4'b0010;
    push(32'h0000_00C1, 1);
    tick();
    en        = 1'b0;
    fifo_full = 1'b1;
    req_valid = 4'b1111;
    #1;
    check("en_ready", 64'(req_ready), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("en_hold_ready", 64'(req_ready), 0);
      check("en_hold_tag", {fifo_wr, fifo_tag}, {1'b1, 2'd1});
    end
    fifo_full = 1'b0;
    #1;
    check("en_drain_ready", 64'(req_ready), 0);
    tick();
    check("en_drained", 64'(fifo_wr), 0);
    en = 1'b1;
    #1;
`ifdef FIFO_ARB_BURST_EN
    check("en_resume", 64'(req_ready), 64'h2);
    push(32'h0000_00C1, 1);
    push(32'h0000_00C1, 1);
`else
    check("en_resume", 64'(req_ready), 64'h4);
    push(32'h0000_00C2, 2);
    push(32'h0000_00C3, 3);
`endif
    tick();
    tick();
    req_valid = '0;
    tick();
    tick();

    // Requesters 0 and 3 continuously valid
    do_reset();
    set_data(0, 32'h0000_00E0);
    set_data(3, 32'h0000_00E3);
    req_valid = 4'b1001;
    for (int k = 0; k < 8; k++) begin
`ifdef FIFO_ARB_BURST_EN
      if ((k / 4) % 2 == 0) push(32'h0000_00E0, 0);
      else                  push(32'h0000_00E3, 3);
`else
      if (k % 2 == 0) push(32'h0000_00E0, 0);
      else            push(32'h0000_00E3, 3);
`endif
    end
    for (int k = 0; k < 8; k++) tick();
    req_valid = '0;
    tick();
    tick();
    check("final_idle", {fifo_wr, busy}, 0);
    check("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares one sync_fifo write port among NREQ independent producers.
- Each producer uses a valid/ready handshake.
- The block owns a single registered output stage that drives the FIFO's wr/data_in, and tags every beat with its source index.
- Sits directly in front of the shared result FIFO; the FIFO's full flag provides backpressure.

Parameters:
- NREQ, 4, number of requesters (2..16)
- DATA_WIDTH, 32, payload width per requester
- ID_WIDTH, $clog2(NREQ), width of source tag
- MAX_BURST, 4, max consecutive beats per grant (used only with the optional feature)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; when low, no new handshakes are accepted, and the output stage still drains
- req_valid  in  NREQ  per-requester beat valid
- req_data  in  NREQ*DATA_WIDTH  packed payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NREQ  per-requester accept (combinational)
- fifo_wr  out  1  write strobe to the FIFO, registered
- fifo_data  out  DATA_WIDTH  payload to the FIFO, registered
- fifo_tag  out  ID_WIDTH  source index of the current fifo_data, registered
- fifo_full  in  1  FIFO full flag
- busy  out  1  high while fifo_wr is high or any req_valid is high

Behaviour:
- Reset (async assert, synchronous release) sets: fifo_wr=0, fifo_data=0, fifo_tag=0, rr_ptr=0, burst_cnt=0, req_ready=0.
- Output stage:
  - It is one register holding a valid bit; fifo_wr is that valid bit.
  - A beat leaves the stage in a cycle where fifo_wr && !fifo_full.
  - While fifo_full is high, fifo_wr/fifo_data/fifo_tag are held stable.
  - The block never drops a beat and never writes while full, so the FIFO's overrun must never assert.
- can_load = !fifo_wr || !fifo_full, i.e. the stage is empty or draining this cycle.
- Arbitration:
  - Search req_valid starting at index rr_ptr, ascending, wrapping at NREQ-1 -> 0.
  - The first set bit is the winner.
  - req_ready[winner] = en && can_load; every other req_ready bit is 0. At most one req_ready bit is ever high.
- Handshake:
  - Requester i transfers when req_valid[i] && req_ready[i].
  - On the next edge: fifo_data <= that requester's payload, fifo_tag <= i, fifo_wr <= 1.
  - Latency is one cycle from handshake to fifo_wr. Throughput is one beat per cycle while the FIFO is not full.
- Pointer update:
  - On each transfer from winner w, rr_ptr <= (w+1) mod NREQ.
  - No transfer leaves rr_ptr unchanged.
- Fairness: with all NREQ requesters continuously valid and no backpressure, grants rotate 0,1,…,NREQ-1,0,…
- Drain: if no transfer occurs in a cycle where the stage drains, fifo_wr <= 0 on the next edge.
- Simultaneous drain and load: the stage is overwritten with the new beat, fifo_wr stays 1, and there is no bubble.
- en low:
  - req_ready is all 0.
  - A pending beat still drains when !fifo_full.
  - rr_ptr is frozen.
- Requesters must hold req_valid/req_data stable until they see ready. The arbiter does not check this.
- Reset mid-operation discards the pending beat; fifo_wr drops immediately (async).

Optional Feature:
- Macro: FIFO_ARB_BURST_EN.
- Defined:
  - After a transfer from w, the grant stays locked on w while req_valid[w] remains high and burst_cnt < MAX_BURST-1.
  - burst_cnt increments per locked transfer.
  - rr_ptr advances to w+1 only when the lock ends, i.e. req_valid[w] is low at arbitration time or the cap is reached; burst_cnt then clears to 0.
  - A requester therefore gets up to MAX_BURST back-to-back beats.
- Undefined: burst_cnt is absent and the pointer advances after every transfer, as described above.

Test Plan:
- Reset then idle, all req_valid=0: fifo_wr=0, busy=0, req_ready=0 for 20 cycles.
- Single requester: req_valid=4'b0100, data 0xA5A5_0002 for 1 beat. Expect req_ready[2]=1 in the same cycle; next cycle fifo_wr=1, fifo_data=0xA5A5_0002, fifo_tag=2; the cycle after, fifo_wr=0.
- All 4 requesters held valid, fifo_full=0, 12 cycles. Expect fifo_tag sequence 0,1,2,3,0,1,2,3,0,1,2,3, with fifo_wr continuously 1 from cycle 2.
- Requester 1 valid with fifo_full=1 for 5 cycles. Expect first beat stuck with fifo_data/fifo_tag stable and req_ready=0 during the hold. After full deasserts: beat drains, next beat loads the same cycle, no bubble.
- en=0 with req_valid=4'b1111: req_ready=0 and rr_ptr unchanged. A pending beat drains when fifo_full=0. Re-enable: grant resumes at the pre-disable rr_ptr.
- FIFO_ARB_BURST_EN defined, MAX_BURST=4, requesters 0 and 3 continuously valid. Expect tags 0,0,0,0,3,3,3,3,0,… Same stimulus without the macro: 0,3,0,3,…
